// File: rtl/serial_subtract_ctrl_if.sv
// serial_subtract_ctrl_if
//   Handshake and operand/result bundle for the bit-serial subtractor.
//   master : drives start/A/B, observes busy/done/Diff/Borrow/Zero
//   slave  : the subtractor side
//   start  request, sampled only while idle
//   A, B   minuend / subtrahend, captured when start is accepted
//   busy   high while bits are being processed
//   done   one-cycle pulse, results valid
//   Diff   A - B mod 2^WIDTH;  Borrow  A < B unsigned;  Zero  Diff == 0
interface serial_subtract_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Zero;

  modport master (output start, A, B,
                  input  busy, done, Diff, Borrow, Zero);
  modport slave  (input  start, A, B,
                  output busy, done, Diff, Borrow, Zero);
endinterface

// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl
//   Bit-serial WIDTH-bit subtractor. One full-subtractor cell processes one bit
//   per clock, LSB first, with a registered borrow between bits.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_subtract_ctrl_if.slave (start/A/B in, busy/done/Diff/Borrow/Zero out)
//   Flow: IDLE --start--> RUN (WIDTH edges) --> DONE (1 cycle) --> IDLE.
//   Diff/Borrow/Zero update only on entry to DONE and hold otherwise.

// Single-bit full subtractor: d = a - b - bin.
module serial_subtract_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtract_ctrl_if.slave bus
);
  // Counter needs at least one bit even for WIDTH = 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             d_bit, bout_bit;
  logic [WIDTH-1:0] res_shift;

  serial_subtract_cell u_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .bin_i (bin_q),
    .d_o   (d_bit),
    .bout_o(bout_bit)
  );

  // New difference bit enters at the MSB; after WIDTH shifts the LSB
  // computed first has reached bit 0.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_shift = d_bit;
    end else begin : g_resn
      assign res_shift = {d_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          res_d   = '0;
          cnt_d   = '0;
          bin_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        bin_d = bout_bit;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d   = res_shift;
          borrow_d = bout_bit;
          zero_d   = (res_shift == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.Diff   = diff_q;
  assign bus.Borrow = borrow_q;
  assign bus.Zero   = zero_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
module tb_serial_subtract_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  serial_subtract_ctrl_if #(.WIDTH(8)) i8 ();
  serial_subtract_ctrl_if #(.WIDTH(1)) i1 ();

  serial_subtract_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  serial_subtract_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain unsigned arithmetic.
  task automatic chk_res8(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ed;
    ed = 8'(a - b);
    chk({tag, "_diff"},   32'(i8.Diff),   32'(ed));
    chk({tag, "_borrow"}, 32'(i8.Borrow), 32'(a < b));
    chk({tag, "_zero"},   32'(i8.Zero),   32'(ed == 8'h00));
  endtask

  // Wait (bounded) for done on the 8-bit DUT; returns edges waited.
  task automatic wait_done8(input bit scramble, output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (scramble) begin
        i8.A = 8'($urandom);
        i8.B = 8'($urandom);
      end else begin
        i8.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (i8.done) break;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input bit hold);
    int n;
    @(negedge clk);
    i8.start = 1'b1; i8.A = a; i8.B = b;
    @(posedge clk); #1;
    chk({tag, "_busy_acc"}, 32'(i8.busy), 32'd1);
    wait_done8(hold, n);
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_done_nbusy"}, 32'(i8.busy), 32'd0);
    chk_res8(tag, a, b);
    if (hold) begin
      // start still high: DONE -> IDLE, then re-accept on the following edge.
      @(posedge clk); #1;
      chk({tag, "_gap_busy"}, 32'(i8.busy), 32'd0);
      chk({tag, "_gap_done"}, 32'(i8.done), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_reaccept"}, 32'(i8.busy), 32'd1);
      chk_res8({tag, "_held"}, a, b);
      wait_done8(1'b0, n);
      chk({tag, "_drain"}, 32'(n), 32'd8);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(i8.done), 32'd0);
    end
  endtask

  task automatic op1(input logic a, input logic b);
    @(negedge clk);
    i1.start = 1'b1; i1.A = a; i1.B = b;
    @(posedge clk); #1;
    chk("w1_busy", 32'(i1.busy), 32'd1);
    @(negedge clk);
    i1.start = 1'b0;
    @(posedge clk); #1;
    chk("w1_done",   32'(i1.done),   32'd1);
    chk("w1_nbusy",  32'(i1.busy),   32'd0);
    chk("w1_diff",   32'(i1.Diff),   32'((a + 2'd2 - b) % 2));
    chk("w1_borrow", 32'(i1.Borrow), 32'(a < b));
    chk("w1_zero",   32'(i1.Zero),   32'(a == b));
    @(posedge clk); #1;
    chk("w1_done_pulse", 32'(i1.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    i8.start = 1'b0; i8.A = '0; i8.B = '0;
    i1.start = 1'b0; i1.A = '0; i1.B = '0;
    #12;
    chk("rst_busy",   32'(i8.busy),   32'd0);
    chk("rst_done",   32'(i8.done),   32'd0);
    chk("rst_diff",   32'(i8.Diff),   32'd0);
    chk("rst_borrow", 32'(i8.Borrow), 32'd0);
    chk("rst_zero",   32'(i8.Zero),   32'd0);
    @(negedge clk); rst_n = 1'b1;

    op8("t1",  8'h35, 8'h12, 1'b0);
    op8("t2a", 8'h12, 8'h35, 1'b0);
    op8("t2b", 8'h00, 8'h01, 1'b0);
    op8("t3a", 8'hAA, 8'hAA, 1'b0);
    op8("t3b", 8'hFF, 8'h00, 1'b0);
    op8("t4",  8'h9C, 8'h47, 1'b1);
    i8.start = 1'b0;
    op8("t4b", 8'h35, 8'h12, 1'b0);

    // Abandon an operation after 3 RUN edges.
    @(negedge clk);
    i8.start = 1'b1; i8.A = 8'h12; i8.B = 8'h35;
    @(posedge clk);
    @(negedge clk); i8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy",   32'(i8.busy),   32'd0);
    chk("mrst_done",   32'(i8.done),   32'd0);
    chk("mrst_diff",   32'(i8.Diff),   32'd0);
    chk("mrst_borrow", 32'(i8.Borrow), 32'd0);
    chk("mrst_zero",   32'(i8.Zero),   32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mrst_nodone", 32'(i8.done), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_after_done", 32'(i8.done), 32'd0);
    op8("t5", 8'h80, 8'h01, 1'b0);

    for (int i = 0; i < 4; i++) op1(1'(i >> 1), 1'(i));

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = (i % 7 == 0) ? ra : 8'($urandom);
      op8("rnd", ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
